uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver that recovers bytes from the serial line driven by the team's transmitter, using 16x oversampling with mid-bit sampling. It uses the same frame format as the transmit path: 1 start bit, 8 data bits LSB first, optional parity, 1 stop bit. Each received byte is presented with a one-cycle valid strobe and per-byte error flags, for capture by a downstream `fifo_sync` (WIDTH=8).

## Interface
- `DIV0`, default 1302, oversample-tick period in clk cycles for `baud_rate`=2'b00 (2400 baud @ 50 MHz)
- `DIV1`, default 651, period for 2'b01 (4800)
- `DIV2`, default 326, period for 2'b10 (9600)
- `DIV3`, default 163, period for 2'b11 (19200)
- `clk`  in  1  system clock
- `rst`  in  1  reset, synchronous, active-high
- `rx`  in  1  asynchronous serial input, idle high
- `baud_rate`  in  2  rate select, encoded as in the transmitter
- `parity_type`  in  2  00 none, 01 odd, 10 even, 11 none
- `data_out`  out  8  last received byte
- `data_valid`  out  1  one-clk strobe, `data_out` and error flags valid
- `parity_err`  out  1  parity mismatch for the current byte, qualified by `data_valid`
- `frame_err`  out  1  stop bit sampled low, qualified by `data_valid`
- `active`  out  1  high from start-edge detection until frame completion

## Operation
- `rx` passes through a 2-flop synchronizer (reset value 1), then one more register for edge detection.
- Tick generator counts 0..DIV-1 and emits a 1-clk `tick` at DIV-1.
  - Its counter is forced to 0 on start-edge detection, so frames are phase-aligned.
- FSM states: IDLE, START, DATA, PARITY, STOP. A 4-bit tick counter (`tcnt`) and a 3-bit bit counter (`bcnt`) are cleared on every state change.
- IDLE:
  - A synchronized falling edge (prev 1, now 0) latches `baud_rate`/`parity_type`, sets `active`, and enters START.
  - A line held low (break) never creates an edge, so no re-trigger occurs.
- START:
  - At tick with `tcnt`=7 (mid-bit), sample the line.
  - Line high: false start; go to IDLE, clear `active`, no output.
  - Line low: enter DATA.
- DATA:
  - At tick with `tcnt`=15, shift the sample into a shift register, MSB-in (LSB is received first).
  - After 8 bits, go to PARITY if parity is enabled, else STOP.
- PARITY:
  - At `tcnt`=15, sample the bit.
  - Expected value: odd = ~^data, even = ^data (the same rule the transmitter uses).
  - Mismatch latches an internal error.
- STOP:
  - At `tcnt`=15, sample the stop bit.
  - Next clk: `data_out` ← shift register, `data_valid`=1, `parity_err` = latched mismatch, `frame_err` = (stop==0).
  - Same cycle: `active`=0, return to IDLE.
- Bytes with errors are still delivered. No backpressure: the consumer must accept on `data_valid`.
- Inputs latched at start are frozen for the frame. Changes to `baud_rate`/`parity_type` mid-frame take effect on the next frame.

## Timing
- Reset values: `data_out`=8'h00, `data_valid`=0, `parity_err`=0, `frame_err`=0, `active`=0, FSM=IDLE, synchronizer=1.
- Edge-detect latency: 3 clk from `rx` falling to `active`=1.
- Sampling points (ticks after start detection): start check at 8, data bit k at 8+16(k+1), parity at 152, stop at 152 (no parity) or 168 (parity).
- `data_valid` rises 1 clk after the stop-bit sample tick and is high exactly 1 clk.
  - `parity_err`/`frame_err` are valid in that cycle; otherwise held at 0.
- Back-to-back frames: a new start edge is accepted the first cycle FSM is IDLE. The stop-bit mid-sample leaves ≥7 ticks of margin.
- `rst` mid-frame: the next clk returns all outputs to reset values. The partial byte is discarded and no `data_valid` is issued.
- Tick and `data_valid` in the same cycle cannot conflict: outputs update only on the STOP→IDLE transition.

## Structure
- Shared package `uart_pkg`: FSM state encoding, parity codes (`PAR_NONE`, `PAR_ODD`, `PAR_EVEN`), default divisor constants. Shared with the transmit path.
- Sub-module `uart_rx_tick` (divisor mux + counter + sync clear → `tick`).
- FSM, counters, shift register and synchronizer stay in `uart_rx`.

## Test plan
- 9600, no parity, send 0xA5 with stop=1 → one `data_valid`, `data_out`=0xA5, both error flags 0, `active` falls the same cycle.
- Odd parity, send 0x00 with parity bit 1 → 0x00, `parity_err`=0. Repeat with parity bit 0 → `parity_err`=1.
- Glitch: `rx` low for 4 ticks then high → no `data_valid`, FSM back to IDLE, `active` pulse ≤ 8 ticks.
- 0x3C with stop bit 0, then line held low 40 ticks, then high → `frame_err`=1 with `data_out`=0x3C. No second frame until a new falling edge.
- Back-to-back 0x55, 0xAA at 19200, even parity, no idle gap → two strobes, correct bytes, no errors.
- Assert `rst` for 1 clk at bit 4 of a frame → all outputs reset next clk, no strobe. The following full frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, parity codes and default baud divisors.
// Used by both the receive and transmit paths so frame rules stay identical.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam logic [1:0] PAR_NONE     = 2'b00;
  localparam logic [1:0] PAR_ODD      = 2'b01;
  localparam logic [1:0] PAR_EVEN     = 2'b10;
  localparam logic [1:0] PAR_NONE_ALT = 2'b11;

  // Oversample-tick periods in clk cycles at 50 MHz.
  localparam int unsigned DIV_2400  = 1302;
  localparam int unsigned DIV_4800  = 651;
  localparam int unsigned DIV_9600  = 326;
  localparam int unsigned DIV_19200 = 163;

  localparam logic [3:0] TCNT_MID  = 4'd7;
  localparam logic [3:0] TCNT_LAST = 4'd15;
  localparam logic [2:0] BCNT_LAST = 3'd7;

  function automatic logic parity_enabled(input logic [1:0] ptype);
    return !(ptype == PAR_NONE || ptype == PAR_NONE_ALT);
  endfunction

  // Parity bit the transmitter appends for a given byte.
  function automatic logic parity_bit(input logic [1:0] ptype, input logic [7:0] data);
    logic pbit;
    case (ptype)
      PAR_ODD:  pbit = ~^data;
      PAR_EVEN: pbit = ^data;
      default:  pbit = 1'b0;
    endcase
    return pbit;
  endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// 16x oversample tick generator: selects the divisor for the latched rate and
// pulses tick for one clk at DIV-1; clr re-phases the counter to a start edge.
module uart_rx_tick
  import uart_pkg::*;
#(
  parameter int unsigned DIV0 = DIV_2400,
  parameter int unsigned DIV1 = DIV_4800,
  parameter int unsigned DIV2 = DIV_9600,
  parameter int unsigned DIV3 = DIV_19200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic [1:0] baud_sel,
  output logic       tick
);

  localparam int CW = 16;

  logic [CW-1:0] div_m1;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          wrap;

  always_comb begin
    case (baud_sel)
      2'b00:   div_m1 = CW'(DIV0 - 1);
      2'b01:   div_m1 = CW'(DIV1 - 1);
      2'b10:   div_m1 = CW'(DIV2 - 1);
      default: div_m1 = CW'(DIV3 - 1);
    endcase
  end

  // A rate change can leave the count above the new limit; wrap rather than run away.
  assign wrap = (cnt_q >= div_m1);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || wrap) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == div_m1) && !clr;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, optional parity, one stop bit, 16x
// oversampling with mid-bit sampling; one-clk data_valid strobe with error flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DIV0 = DIV_2400,
  parameter int unsigned DIV1 = DIV_4800,
  parameter int unsigned DIV2 = DIV_9600,
  parameter int unsigned DIV3 = DIV_19200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic [1:0] baud_rate,
  input  logic [1:0] parity_type,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       active
);

  // sync_q[0..1] are the metastability stages, sync_q[2] the previous sample for edge detect.
  logic [2:0] sync_q;
  logic [2:0] sync_d;
  logic       rx_s;
  logic       start_edge;
  logic       tick;

  rx_state_e  state_q;
  rx_state_e  state_d;
  logic [3:0] tcnt_q;
  logic [3:0] tcnt_d;
  logic [2:0] bcnt_q;
  logic [2:0] bcnt_d;
  logic [7:0] shift_q;
  logic [7:0] shift_d;
  logic [1:0] baud_q;
  logic [1:0] baud_d;
  logic [1:0] par_q;
  logic [1:0] par_d;
  logic       par_err_q;
  logic       par_err_d;

  logic [7:0] data_out_q;
  logic [7:0] data_out_d;
  logic       data_valid_q;
  logic       data_valid_d;
  logic       parity_err_q;
  logic       parity_err_d;
  logic       frame_err_q;
  logic       frame_err_d;
  logic       active_q;
  logic       active_d;

  logic       mid_hit;
  logic       end_hit;

  assign sync_d     = {sync_q[1:0], rx};
  assign rx_s       = sync_q[1];
  assign start_edge = (state_q == ST_IDLE) && sync_q[2] && !sync_q[1];
  assign mid_hit    = tick && (tcnt_q == TCNT_MID);
  assign end_hit    = tick && (tcnt_q == TCNT_LAST);

  uart_rx_tick #(
    .DIV0(DIV0),
    .DIV1(DIV1),
    .DIV2(DIV2),
    .DIV3(DIV3)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .clr     (start_edge),
    .baud_sel(baud_q),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_edge) state_d = ST_START;
      end
      ST_START: begin
        if (mid_hit) state_d = rx_s ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (end_hit && (bcnt_q == BCNT_LAST)) begin
          state_d = parity_enabled(par_q) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (end_hit) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (end_hit) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counters, shift register and frame-scoped latches.
  always_comb begin
    tcnt_d    = tcnt_q;
    bcnt_d    = bcnt_q;
    shift_d   = shift_q;
    baud_d    = baud_q;
    par_d     = par_q;
    par_err_d = par_err_q;

    if (state_d != state_q) begin
      tcnt_d = '0;
      bcnt_d = '0;
    end else begin
      if (tick) tcnt_d = tcnt_q + 4'd1;
      if (state_q == ST_DATA && end_hit) bcnt_d = bcnt_q + 3'd1;
    end

    if (start_edge) begin
      baud_d    = baud_rate;
      par_d     = parity_type;
      par_err_d = 1'b0;
    end

    if (state_q == ST_DATA && end_hit) begin
      shift_d = {rx_s, shift_q[7:1]};
    end

    if (state_q == ST_PARITY && end_hit) begin
      par_err_d = (rx_s != parity_bit(par_q, shift_q));
    end
  end

  // Registered outputs change only on start detection and frame exit.
  always_comb begin
    active_d     = active_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_edge) active_d = 1'b1;
      end
      ST_START: begin
        if (state_d == ST_IDLE) active_d = 1'b0;
      end
      ST_STOP: begin
        if (state_d == ST_IDLE) begin
          active_d     = 1'b0;
          data_out_d   = shift_q;
          data_valid_d = 1'b1;
          parity_err_d = par_err_q;
          frame_err_d  = !rx_s;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q       <= 3'b111;
      tcnt_q       <= '0;
      bcnt_q       <= '0;
      shift_q      <= '0;
      baud_q       <= '0;
      par_q        <= PAR_NONE;
      par_err_q    <= 1'b0;
      data_out_q   <= 8'h00;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      tcnt_q       <= tcnt_d;
      bcnt_q       <= bcnt_d;
      shift_q      <= shift_d;
      baud_q       <= baud_d;
      par_q        <= par_d;
      par_err_q    <= par_err_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      active_q     <= active_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign active     = active_q;

  a_valid_single: assert property (@(posedge clk) disable iff (rst)
    data_valid_q |=> !data_valid_q);
  a_flags_qualified: assert property (@(posedge clk) disable iff (rst)
    !data_valid_q |-> !(parity_err_q || frame_err_q));

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: drives serial frames and checks every strobe
// against a queue of bytes/flags predicted from the frame contents.
module tb_uart_rx;

  localparam int D0 = 10;
  localparam int D1 = 8;
  localparam int D2 = 6;
  localparam int D3 = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic [1:0] baud_rate = 2'b10;
  logic [1:0] parity_type = 2'b00;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       active;

  uart_rx #(
    .DIV0(D0),
    .DIV1(D1),
    .DIV2(D2),
    .DIV3(D3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .baud_rate  (baud_rate),
    .parity_type(parity_type),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .active     (active)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   strobes = 0;
  int   flag_viol = 0;
  int   active_len = 0;
  int   last_active_len = 0;
  logic prev_valid = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: every strobe consumes one predicted frame.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (data_valid) begin
        strobes++;
        $display("rx byte=%02h parity_err=%0b frame_err=%0b", data_out, parity_err, frame_err);
        if (exp_q.size() == 0) begin
          check_eq("spurious_strobe", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("data_out", {24'd0, data_out}, {24'd0, mon_e.data});
          check_eq("parity_err", {31'd0, parity_err}, {31'd0, mon_e.perr});
          check_eq("frame_err", {31'd0, frame_err}, {31'd0, mon_e.ferr});
        end
        check_eq("active_low_at_valid", {31'd0, active}, 32'd0);
        if (prev_valid) flag_viol++;
      end else if (parity_err || frame_err) begin
        flag_viol++;
      end
      if (active) begin
        active_len++;
      end else begin
        if (active_len != 0) last_active_len = active_len;
        active_len = 0;
      end
    end
    prev_valid = data_valid;
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic int div_of(input logic [1:0] b);
    case (b)
      2'b00:   return D0;
      2'b01:   return D1;
      2'b10:   return D2;
      default: return D3;
    endcase
  endfunction

  task automatic hold(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int div);
    rx = b;
    hold(16 * div);
  endtask

  // Full frame; the expected result is derived from the bits put on the wire.
  task automatic send_frame(input logic [7:0] data, input logic [1:0] br, input logic [1:0] pt,
                            input bit bad_par, input logic stop, input bit chk_lat, input bit scramble);
    int   div;
    int   ones;
    bit   pen;
    logic pbit;
    exp_t e;
    div  = div_of(br);
    ones = $countones(data);
    pen  = (pt == 2'b01) || (pt == 2'b10);
    pbit = (pt == 2'b01) ? (ones % 2 == 0) : (ones % 2 == 1);
    if (bad_par) pbit = ~pbit;
    e.data = data;
    e.perr = pen && bad_par;
    e.ferr = (stop == 1'b0);
    exp_q.push_back(e);
    baud_rate   = br;
    parity_type = pt;
    rx = 1'b0;
    if (chk_lat) begin
      repeat (2) @(posedge clk);
      #1 check_eq("active_before_lat3", {31'd0, active}, 32'd0);
      @(posedge clk);
      #1 check_eq("active_at_lat3", {31'd0, active}, 32'd1);
      hold(16 * div - 2);
    end else begin
      hold(16 * div);
    end
    if (scramble) begin
      baud_rate   = 2'($urandom_range(0, 3));
      parity_type = 2'($urandom_range(0, 3));
    end
    for (int i = 0; i < 8; i++) send_bit(data[i], div);
    if (pen) send_bit(pbit, div);
    send_bit(stop, div);
  endtask

  int s0;

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_data_out", {24'd0, data_out}, 32'd0);
    check_eq("rst_data_valid", {31'd0, data_valid}, 32'd0);
    check_eq("rst_parity_err", {31'd0, parity_err}, 32'd0);
    check_eq("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check_eq("rst_active", {31'd0, active}, 32'd0);
    rst = 1'b0;
    hold(20);

    // 9600, no parity, 0xA5 with edge-detect latency check
    send_frame(8'hA5, 2'b10, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    hold(4 * D2);

    // odd parity on 0x00: good parity bit, then wrong parity bit
    send_frame(8'h00, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h00, 2'b00, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    hold(4 * D0);

    // glitch: low for 4 ticks only
    s0 = strobes;
    baud_rate = 2'b10;
    parity_type = 2'b00;
    rx = 1'b0;
    hold(4 * D2);
    rx = 1'b1;
    hold(16 * D2);
    check_eq("glitch_active_le_8ticks", {31'd0, last_active_len <= 8 * D2}, 32'd1);
    check_eq("glitch_active_seen", {31'd0, last_active_len > 0}, 32'd1);
    check_eq("glitch_no_strobe", strobes, s0);
    check_eq("glitch_idle", {31'd0, active}, 32'd0);

    // stop bit low, then break for 40 ticks
    s0 = strobes;
    send_frame(8'h3C, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    rx = 1'b0;
    hold(40 * D2);
    rx = 1'b1;
    hold(20 * D2);
    check_eq("break_single_strobe", strobes - s0, 32'd1);

    // back-to-back at 19200, even parity
    s0 = strobes;
    send_frame(8'h55, 2'b11, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'hAA, 2'b11, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
    hold(4 * D3);
    check_eq("b2b_two_strobes", strobes - s0, 32'd2);

    // reset in the middle of data bit 4
    s0 = strobes;
    baud_rate = 2'b10;
    parity_type = 2'b00;
    send_bit(1'b0, D2);
    for (int i = 0; i < 4; i++) send_bit(i[0], D2);
    rx = 1'b0;
    hold(8 * D2);
    rst = 1'b1;
    rx = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_data_out", {24'd0, data_out}, 32'd0);
    check_eq("midrst_data_valid", {31'd0, data_valid}, 32'd0);
    check_eq("midrst_active", {31'd0, active}, 32'd0);
    check_eq("midrst_flags", {30'd0, parity_err, frame_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    hold(20 * D2);
    check_eq("midrst_no_strobe", strobes, s0);
    send_frame(8'h81, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    hold(4 * D2);

    // randomized frames, inputs scrambled mid-frame
    for (int n = 0; n < 16; n++) begin
      logic [7:0] d;
      logic [1:0] br;
      logic [1:0] pt;
      bit         bad;
      logic       stp;
      d   = 8'($urandom_range(0, 255));
      br  = 2'($urandom_range(0, 3));
      pt  = 2'($urandom_range(0, 3));
      bad = ($urandom_range(0, 3) == 0);
      stp = ($urandom_range(0, 4) != 0);
      send_frame(d, br, pt, bad, stp, 1'b0, 1'b1);
      rx = 1'b1;
      if (stp) hold($urandom_range(0, 3) * div_of(br));
      else     hold((2 + $urandom_range(0, 3)) * div_of(br));
    end

    for (int w = 0; w < 4000 && exp_q.size() != 0; w++) @(negedge clk);
    hold(10);
    check_eq("expected_queue_drained", exp_q.size(), 32'd0);
    check_eq("flag_qualification", flag_viol, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
